// File: rtl/spi_frame_ctrl.sv
// spi_frame_ctrl: SPI mode-0 front end for the configuration register bank.
// Synchronizes sclk/copi/ncs into clk, deserializes 16-bit MSB-first frames
// {read_write, addr[6:0], data[7:0]}, validates them and issues a one-cycle
// valid strobe. Optional ncs-stuck-low abort is built with `define SPI_TIMEOUT_EN.
module spi_frame_ctrl #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter logic [6:0]  MAX_ADDR       = 7'h04,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       valid,
  output logic       read_write,
  output logic [6:0] addr,
  output logic [7:0] data,
  output logic       frame_err,
  output logic       addr_err,
  output logic       busy
`ifdef SPI_TIMEOUT_EN
  ,
  output logic       timeout
`endif
);

  if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("spi_frame_ctrl: SYNC_STAGES and TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [2:0] {WAIT_IDLE, IDLE, SHIFT, OVERRUN, ISSUE} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, copi_sync_q, ncs_sync_q, prime_q;
  logic                   sclk_prev_q, ncs_prev_q;
  logic [4:0]             cnt_q, cnt_d;
  logic [15:0]            shift_q, shift_d;
  logic                   valid_q, valid_d, ferr_q, ferr_d, aerr_q, aerr_d;
  logic                   rw_q, rw_d;
  logic [6:0]             addr_q, addr_d;
  logic [7:0]             data_q, data_d;
  logic                   sclk_s, copi_s, ncs_s, sclk_rise, ncs_rise, ncs_fall;

`ifdef SPI_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tout_q, tout_d;
  assign timeout = tout_q;
`endif

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign copi_s    = copi_sync_q[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign ncs_rise  = ncs_s & ~ncs_prev_q;
  assign ncs_fall  = ~ncs_s & ncs_prev_q;

  // Input synchronizers, edge-detect history and synchronizer-flush tracker.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_sync_q  <= '1;
      prime_q     <= '0;
      sclk_prev_q <= 1'b0;
      ncs_prev_q  <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
      prime_q     <= {prime_q[SYNC_STAGES-2:0], 1'b1};
      sclk_prev_q <= sclk_s;
      ncs_prev_q  <= ncs_s;
    end
  end

  // State, frame datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      aerr_q  <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
`ifdef SPI_TIMEOUT_EN
      tmo_q   <= '0;
      tout_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      aerr_q  <= aerr_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
`ifdef SPI_TIMEOUT_EN
      tmo_q   <= tmo_d;
      tout_q  <= tout_d;
`endif
    end
  end

  // Next-state and output decisions.
  // Frame validation is decided on the SHIFT->ISSUE transition so the
  // registered strobe/fields are presented exactly during the ISSUE cycle.
  // WAIT_IDLE also waits for the synchronizer to refill after reset, since
  // its reset value ncs=1 does not reflect the pin.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    aerr_d  = 1'b0;
    rw_d    = rw_q;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef SPI_TIMEOUT_EN
    tmo_d   = tmo_q;
    tout_d  = 1'b0;
`endif
    case (state_q)
      WAIT_IDLE: if (prime_q[SYNC_STAGES-1] && ncs_s) state_d = IDLE;
      IDLE: if (ncs_fall) begin
        cnt_d   = '0;
        shift_d = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (ncs_rise) begin
          state_d = ISSUE;
          if (cnt_q != 5'd16) begin
            ferr_d = 1'b1;
          end else if (shift_q[14:8] > MAX_ADDR) begin
            aerr_d = 1'b1;
          end else begin
            valid_d = 1'b1;
            rw_d    = shift_q[15];
            addr_d  = shift_q[14:8];
            data_d  = shift_q[7:0];
          end
        end else if (sclk_rise && !ncs_s) begin
          if (cnt_q == 5'd16) begin
            state_d = OVERRUN;
          end else begin
            shift_d = {shift_q[14:0], copi_s};
            cnt_d   = cnt_q + 5'd1;
          end
        end
      end
      OVERRUN: if (ncs_rise) begin
        ferr_d  = 1'b1;
        state_d = IDLE;
      end
      ISSUE: begin
        if (ncs_fall) begin
          cnt_d   = '0;
          shift_d = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
`ifdef SPI_TIMEOUT_EN
    if (state_q == SHIFT || state_q == OVERRUN) begin
      if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d = WAIT_IDLE;
        valid_d = 1'b0;
        aerr_d  = 1'b0;
        ferr_d  = 1'b1;
        tout_d  = 1'b1;
        rw_d    = rw_q;
        addr_d  = addr_q;
        data_d  = data_q;
      end
      tmo_d = tmo_q + TW'(1);
    end
    if (state_d != state_q) tmo_d = '0;
`endif
  end

  assign valid      = valid_q;
  assign frame_err  = ferr_q;
  assign addr_err   = aerr_q;
  assign read_write = rw_q;
  assign addr       = addr_q;
  assign data       = data_q;
  assign busy       = (state_q != IDLE);

endmodule
